fetch_ctrl: RTL and testbench

Sequences the fetch stage around the next-PC unit for the pipelined MIPS core. It owns the F-stage PC register and the F/D pipeline register, and drives a req/ack handshake to the instruction memory so that IM can become multi-cycle. It applies the D-stage control-transfer decision with one architectural delay slot, and honours the hazard unit's D-stage stall. NPC stays combinational and outside this block: it reads instr_d/pc8_d and returns its result on target_d.

---
 rtl/fetch_ctrl_pkg.sv | 13 +
 rtl/fetch_ctrl_fd_reg.sv | 44 ++++
 rtl/fetch_ctrl.sv | 106 ++++++++++
 tb/tb_fetch_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and state encoding for the fetch controller.
package fetch_ctrl_pkg;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

   // FETCH: a request is outstanding; FULL: one fetched word parked in the buffer
   typedef enum logic {
      FETCH = 1'b0,
      FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/fetch_ctrl_fd_reg.sv
// F/D pipeline register: loads a fetched word or a bubble when enabled, holds otherwise.
module fetch_ctrl_fd_reg
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_en,
   input  logic        i_fill,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc8,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc8,
   output logic        o_valid
);

   logic [31:0] r_instr;
   logic [31:0] r_pc8;
   logic        r_valid;

   // Fill loads the word; an enabled cycle without a word inserts a bubble and keeps pc8
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr <= NOP_INSTR;
         r_pc8   <= 32'h0;
         r_valid <= 1'b0;
      end else if (i_en) begin
         if (i_fill) begin
            r_instr <= i_instr;
            r_pc8   <= i_pc8;
            r_valid <= 1'b1;
         end else begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
         end
      end
   end

   assign o_instr = r_instr;
   assign o_pc8   = r_pc8;
   assign o_valid = r_valid;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns pc_f, the IM req/ack handshake and the F/D register,
// applying D-stage redirects with one delay slot.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_d,
   input  logic        redirect_d,
   input  logic [31:0] target_d,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_ack,
   input  logic [31:0] im_rdata,
   output logic [31:0] pc_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc8_d,
   output logic        valid_d
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_buf;
   logic        r_pend_v;
   logic [31:0] r_pend_tgt;

   logic        w_adv;
   logic        w_got;
   logic        w_take;
   logic        w_fill;
   logic [31:0] w_word;

   assign w_adv  = ~stall_d;
   assign w_got  = (r_state == FETCH) & im_ack;
   assign w_take = valid_d & redirect_d & w_adv;
   assign w_fill = w_adv & ((r_state == FULL) | w_got);
   // A parked word always wins over the bus; the bus is only meaningful with ack
   assign w_word = (r_state == FULL) ? r_buf : im_rdata;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= FETCH;
      else        r_state <= w_state_nxt;
   end

   // Next state and request; request is killed combinationally during reset
   always_comb begin
      w_state_nxt = r_state;
      im_req      = 1'b0;
      case (r_state)
         FETCH: begin
            im_req = reset;
            if (w_got && stall_d) w_state_nxt = FULL;
         end
         FULL: begin
            if (w_adv) w_state_nxt = FETCH;
         end
         default: w_state_nxt = FETCH;
      endcase
   end

   // PC advance, pending-redirect bookkeeping and the park buffer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc       <= RESET_PC;
         r_buf      <= 32'h0;
         r_pend_v   <= 1'b0;
         r_pend_tgt <= 32'h0;
      end else begin
         if (w_got && stall_d) r_buf <= im_rdata;
         if (w_fill) begin
            // take wins over a pending target (branch-in-delay-slot is undefined)
            if (w_take)        r_pc <= target_d;
            else if (r_pend_v) r_pc <= r_pend_tgt;
            else               r_pc <= r_pc + 32'd4;
            r_pend_v <= 1'b0;
         end else if (w_take) begin
            // delay slot not fetched yet: remember the target until its fill
            r_pend_v   <= 1'b1;
            r_pend_tgt <= target_d;
         end
      end
   end

   fetch_ctrl_fd_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_fd_reg (
      .clk     (clk),
      .rst_n   (reset),
      .i_en    (w_adv),
      .i_fill  (w_fill),
      .i_instr (w_word),
      .i_pc8   (r_pc + 32'd8),
      .o_instr (instr_d),
      .o_pc8   (pc8_d),
      .o_valid (valid_d)
   );

   assign pc_f    = r_pc;
   assign im_addr = r_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a fetch-stream reference model and per-cycle compare.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_d;
   logic        redirect_d;
   logic [31:0] target_d;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ack;
   logic [31:0] im_rdata;
   logic [31:0] pc_f;
   logic [31:0] instr_d;
   logic [31:0] pc8_d;
   logic        valid_d;

   // Branch stimulus: the instruction fetched from br_pc is treated as a taken branch
   logic        br_en;
   logic [31:0] br_pc;
   logic [31:0] br_tgt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Memory image: every word is a recognisable tag of its own address
   function automatic logic [31:0] W(input logic [31:0] a);
      return a ^ 32'hC000_0000;
   endfunction

   assign im_rdata   = im_ack ? W(im_addr) : 32'hDEAD_BEEF;
   assign redirect_d = br_en && (instr_d == W(br_pc));
   assign target_d   = br_tgt;

   fetch_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .stall_d    (stall_d),
      .redirect_d (redirect_d),
      .target_d   (target_d),
      .im_req     (im_req),
      .im_addr    (im_addr),
      .im_ack     (im_ack),
      .im_rdata   (im_rdata),
      .pc_f       (pc_f),
      .instr_d    (instr_d),
      .pc8_d      (pc8_d),
      .valid_d    (valid_d)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a fetch pointer, whether the word at it is parked,
   // a pending target, and the D contents.
   logic [31:0] m_pc, m_pt, m_instr, m_pc8;
   logic        m_parked, m_pv, m_valid, m_redir;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pc = 32'h3000; m_parked = 0; m_pv = 0; m_pt = 0;
         m_instr = 0; m_pc8 = 0; m_valid = 0;
      end else begin
         m_redir = br_en && m_valid && (m_instr == W(br_pc));
         if (!stall_d) begin
            if (m_parked || im_ack) begin
               // the word at the fetch pointer moves into D
               m_instr = W(m_pc); m_valid = 1; m_pc8 = m_pc + 8;
               if (m_redir)   m_pc = br_tgt;
               else if (m_pv) m_pc = m_pt;
               else           m_pc = m_pc + 4;
               m_pv = 0; m_parked = 0;
            end else begin
               m_instr = 0; m_valid = 0;
               if (m_redir) begin m_pv = 1; m_pt = br_tgt; end
            end
         end else if (im_ack) begin
            m_parked = 1;
         end
      end
   end

   // Compare every cycle, mid-cycle away from the edge
   always @(negedge clk) begin
      chk("req",   {31'b0, im_req},  {31'b0, reset && !m_parked});
      chk("addr",  im_addr,          m_pc);
      chk("pc_f",  pc_f,             m_pc);
      chk("instr", instr_d,          m_instr);
      chk("pc8",   pc8_d,            m_pc8);
      chk("valid", {31'b0, valid_d}, {31'b0, m_valid});
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},   {31'b0, im_req},  32'h0);
      chk({tag, "_pc"},    pc_f,             32'h3000);
      chk({tag, "_instr"}, instr_d,          32'h0);
      chk({tag, "_pc8"},   pc8_d,            32'h0);
      chk({tag, "_valid"}, {31'b0, valid_d}, 32'h0);
   endtask

   // Reset, then run zero-wait until the word at 0x300C sits in D and pc_f=0x3010
   task automatic reach_branch();
      reset = 0; stall_d = 0; im_ack = 1;
      br_en = 1; br_pc = 32'h300C; br_tgt = 32'h3100;
      #1 chk_reset_vals("rb_rst");
      step();
      reset = 1;
      repeat (4) step();
      chk("rb_instr", instr_d, W(32'h300C));
      chk("rb_addr",  im_addr, 32'h3010);
   endtask

   initial begin
      reset = 0; stall_d = 0; im_ack = 1;
      br_en = 1; br_pc = 32'h3004; br_tgt = 32'h3040;
      repeat (2) step();
      chk_reset_vals("t1_rst");

      // 1+2: zero-wait stream with a taken branch at 0x3004
      reset = 1;
      #1 chk("t1_addr0", im_addr, 32'h3000);
      chk("t1_req0", {31'b0, im_req}, 32'h1);
      step();
      chk("t1_instr0", instr_d, W(32'h3000));
      chk("t1_pc8",    pc8_d,   32'h3008);
      chk("t1_addr1",  im_addr, 32'h3004);
      step();
      chk("t2_addr_ds", im_addr, 32'h3008);
      chk("t2_br_in_d", instr_d, W(32'h3004));
      step();
      chk("t2_addr_tgt", im_addr, 32'h3040);
      chk("t2_ds_in_d",  instr_d, W(32'h3008));
      chk("t2_valid",    {31'b0, valid_d}, 32'h1);
      step();
      chk("t2_tgt_in_d", instr_d, W(32'h3040));
      br_en = 0;

      // 3: two stall cycles with ack high park the word; release with the bus idle
      stall_d = 1;
      step();
      chk("t3_req",  {31'b0, im_req}, 32'h0);
      chk("t3_pc",   pc_f, 32'h3044);
      step();
      chk("t3_hold", instr_d, W(32'h3040));
      stall_d = 0; im_ack = 0;
      step();
      chk("t3_buf_in_d", instr_d, W(32'h3044));
      chk("t3_addr",     im_addr, 32'h3048);

      // 4: three cycles without ack give bubbles and a stable address
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_valid", {31'b0, valid_d}, 32'h0);
         chk("t4_addr",  im_addr, 32'h3048);
      end
      im_ack = 1;
      step();
      chk("t4_instr", instr_d, W(32'h3048));

      // 5: jr in D while the delay slot is still waiting for ack
      reach_branch();
      im_ack = 0;
      step();
      chk("t5_addr_wait", im_addr, 32'h3010);
      im_ack = 1;
      step();
      chk("t5_ds_in_d", instr_d, W(32'h3010));
      chk("t5_addr_tgt", im_addr, 32'h3100);

      // 6: async reset while FULL with a redirect pending
      reach_branch();
      im_ack = 0;
      step();
      stall_d = 1; im_ack = 1;
      step();
      chk("t6_full_req", {31'b0, im_req}, 32'h0);
      #1 reset = 0;
      #1 chk_reset_vals("t6_rst");
      step();
      stall_d = 0; br_en = 0;
      reset = 1;
      #1 chk("t6_addr0", im_addr, 32'h3000);
      step();
      chk("t6_instr", instr_d, W(32'h3000));
      chk("t6_addr1", im_addr, 32'h3004);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
